// File: rtl/ats21_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ats21_pkg
//  Description : Shared opcodes, ctrlA field layout and stat codes for ATS21.
//  Revision    : 1.0 - initial release
// ============================================================================
package ats21_pkg;

    localparam int c_def_num_alarms  = 24;
    localparam int c_def_num_clocks  = 16;
    localparam int c_def_clock_width = 16;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_CLK_EN   = 3'd1,
        OP_CLK_DIS  = 3'd2,
        OP_CLK_LOAD = 3'd3,
        OP_ALM_SET  = 3'd4,
        OP_ALM_DIS  = 3'd5,
        OP_ALM_CLR  = 3'd6,
        OP_CR_WRITE = 3'd7
    } ats21_op_e;

    localparam int c_ctrla_op_lsb    = 13;
    localparam int c_ctrla_clock_lsb = 9;
    localparam int c_ctrla_alarm_lsb = 4;
    localparam int c_ctrla_loop_bit  = 3;

    // STAT_NONE is also what a timed-out command reports
    localparam logic [1:0] c_stat_none = 2'b00;
    localparam logic [1:0] c_stat_ok   = 2'b01;
    localparam logic [1:0] c_stat_err  = 2'b10;
    localparam logic [1:0] c_stat_rsvd = 2'b11;

    function automatic logic [15:0] encode_ctrla(
        input logic [2:0] op,
        input logic [3:0] clock,
        input logic [4:0] alarm,
        input logic       loop
    );
        logic [15:0] w_word;
        w_word                           = '0;
        w_word[c_ctrla_op_lsb    +: 3]   = op;
        w_word[c_ctrla_clock_lsb +: 4]   = clock;
        w_word[c_ctrla_alarm_lsb +: 5]   = alarm;
        w_word[c_ctrla_loop_bit]         = loop;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ats21_alarm_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : ats21_alarm_monitor
//  Description : Rising-edge capture of alarm-finished bits into sticky flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ats21_alarm_monitor
    import ats21_pkg::*;
#(
    parameter int NUM_ALARMS = c_def_num_alarms
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_ALARMS-1:0] data,
    input  logic [NUM_ALARMS-1:0] alarm_clear,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  alarm_irq
);

    logic [NUM_ALARMS-1:0] r_data_q;
    logic [NUM_ALARMS-1:0] r_pending;
    logic                  r_irq;
    logic [NUM_ALARMS-1:0] w_rise;

    assign w_rise = data & ~r_data_q;

    // set has priority over clear on the same bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_q  <= '0;
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_data_q  <= data;
            r_pending <= (r_pending & ~alarm_clear) | w_rise;
            r_irq     <= |r_pending;
        end
    end

    assign alarm_pending = r_pending;
    assign alarm_irq     = r_irq;

endmodule
`default_nettype wire

// File: rtl/ats21_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : ats21_host_if
//  Description : ATS21 initiator - command encode, req/ready handshake with
//                timeout, and alarm-finished monitoring.
//  Revision    : 1.0 - initial release
// ============================================================================
module ats21_host_if
    import ats21_pkg::*;
#(
    parameter int NUM_ALARMS  = c_def_num_alarms,
    parameter int NUM_CLOCKS  = c_def_num_clocks,
    parameter int CLOCK_WIDTH = c_def_clock_width,
    parameter int TIMEOUT     = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [$clog2(NUM_CLOCKS)-1:0] cmd_clock,
    input  logic [4:0]                    cmd_alarm,
    input  logic                          cmd_loop,
    input  logic [CLOCK_WIDTH-1:0]        cmd_value,
    output logic                          resp_valid,
    output logic [1:0]                    resp_stat,
    output logic                          resp_timeout,
    output logic                          req,
    output logic [15:0]                   ctrlA,
    output logic [CLOCK_WIDTH-1:0]        ctrlB,
    input  logic                          ready,
    input  logic [1:0]                    stat,
    input  logic [NUM_ALARMS-1:0]         data,
    input  logic [NUM_ALARMS-1:0]         alarm_clear,
    output logic [NUM_ALARMS-1:0]         alarm_pending,
    output logic                          alarm_irq
);

    localparam int                 c_cnt_w    = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_resp  = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_cnt_w-1:0]     r_wait_cnt;
    logic [15:0]            r_ctrla;
    logic [CLOCK_WIDTH-1:0] r_ctrlb;
    logic [1:0]             r_resp_stat;
    logic                   r_resp_timeout;
    logic                   w_accept;
    logic                   w_ack;
    logic                   w_expire;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack       = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_issue: begin
                // ready on the last allowed cycle still counts as success
                if (ready) begin
                    w_ack       = 1'b1;
                    w_state_nxt = c_st_resp;
                end else if (r_wait_cnt == c_cnt_last) begin
                    w_expire    = 1'b1;
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_wait_cnt     <= '0;
            r_ctrla        <= '0;
            r_ctrlb        <= '0;
            r_resp_stat    <= c_stat_none;
            r_resp_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ctrla    <= encode_ctrla(cmd_op, 4'(cmd_clock), cmd_alarm, cmd_loop);
                r_ctrlb    <= cmd_value;
                r_wait_cnt <= '0;
            end else if (r_state == c_st_issue) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_ack) begin
                r_resp_stat    <= stat;
                r_resp_timeout <= 1'b0;
            end else if (w_expire) begin
                r_resp_stat    <= c_stat_none;
                r_resp_timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready    = (r_state == c_st_idle);
    assign req          = (r_state == c_st_issue);
    assign resp_valid   = (r_state == c_st_resp);
    assign resp_stat    = r_resp_stat;
    assign resp_timeout = r_resp_timeout;
    assign ctrlA        = r_ctrla;
    assign ctrlB        = r_ctrlb;

    ats21_alarm_monitor #(
        .NUM_ALARMS (NUM_ALARMS)
    ) u_alarm_monitor (
        .clk           (clk),
        .reset         (reset),
        .data          (data),
        .alarm_clear   (alarm_clear),
        .alarm_pending (alarm_pending),
        .alarm_irq     (alarm_irq)
    );

endmodule
`default_nettype wire

// File: tb/tb_ats21_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ats21_host_if
//  Description : Self-checking bench for ats21_host_if.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ats21_host_if;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_clock;
    logic [4:0]  cmd_alarm;
    logic        cmd_loop;
    logic [15:0] cmd_value;
    logic        resp_valid;
    logic [1:0]  resp_stat;
    logic        resp_timeout;
    logic        req;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic        ready;
    logic [1:0]  stat;
    logic [23:0] data;
    logic [23:0] alarm_clear;
    logic [23:0] alarm_pending;
    logic        alarm_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ats21_host_if #(
        .NUM_ALARMS  (24),
        .NUM_CLOCKS  (16),
        .CLOCK_WIDTH (16),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_clock     (cmd_clock),
        .cmd_alarm     (cmd_alarm),
        .cmd_loop      (cmd_loop),
        .cmd_value     (cmd_value),
        .resp_valid    (resp_valid),
        .resp_stat     (resp_stat),
        .resp_timeout  (resp_timeout),
        .req           (req),
        .ctrlA         (ctrlA),
        .ctrlB         (ctrlB),
        .ready         (ready),
        .stat          (stat),
        .data          (data),
        .alarm_clear   (alarm_clear),
        .alarm_pending (alarm_pending),
        .alarm_irq     (alarm_irq)
    );

    typedef struct {
        logic [23:0] d;
        logic [23:0] clr;
        logic [23:0] pend;
        logic        irq;
    } alm_vec_t;

    alm_vec_t vecs [10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One complete command; dly = idle ISSUE cycles before ready (>= TIMEOUT means never)
    task automatic do_cmd(input logic [2:0] op, input logic [3:0] ck, input logic [4:0] al,
                          input logic lp, input logic [15:0] val, input int dly,
                          input logic [1:0] st, input string nm);
        logic [15:0] ea;
        bit          tmo;
        bit          stable;
        int          nreq;
        int          w;
        ea  = 16'(int'(op) * 8192 + int'(ck) * 512 + int'(al) * 16 + int'(lp) * 8);
        tmo = (dly >= TIMEOUT);
        w   = 0;
        while (!cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({nm, "_cmd_ready_idle"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_clock = ck;
        cmd_alarm = al;
        cmd_loop  = lp;
        cmd_value = val;
        stat      = st;
        ready     = 1'($urandom_range(0, 1));
        @(negedge clk);
        cmd_valid = 1'b0;
        ready     = 1'b0;
        check({nm, "_cmd_ready_busy"}, cmd_ready, 0);
        nreq   = 0;
        stable = 1'b1;
        while (req && nreq < TIMEOUT + 4) begin
            if (ctrlA !== ea || ctrlB !== val || resp_valid !== 1'b0) stable = 1'b0;
            ready = (nreq == dly);
            nreq++;
            @(negedge clk);
        end
        ready = 1'b0;
        check({nm, "_req_cycles"}, nreq, tmo ? TIMEOUT : dly + 1);
        check({nm, "_ctrl_stable"}, stable, 1);
        check({nm, "_resp_valid"}, resp_valid, 1);
        check({nm, "_resp_timeout"}, resp_timeout, tmo);
        check({nm, "_resp_stat"}, resp_stat, tmo ? 2'b00 : st);
        @(negedge clk);
        check({nm, "_resp_one_cycle"}, resp_valid, 0);
        check({nm, "_cmd_ready_back"}, cmd_ready, 1);
    endtask

    initial begin
        logic [23:0] prev, mp, np, d, c;
        logic        eirq;
        int          gap;
        int          dly;

        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_clock   = '0;
        cmd_alarm   = '0;
        cmd_loop    = 1'b0;
        cmd_value   = '0;
        ready       = 1'b0;
        stat        = '0;
        data        = '0;
        alarm_clear = '0;

        vecs[0] = '{24'h000080, 24'h000000, 24'h000080, 1'b0};
        vecs[1] = '{24'h000080, 24'h000000, 24'h000080, 1'b1};
        vecs[2] = '{24'h000000, 24'h000000, 24'h000080, 1'b1};
        vecs[3] = '{24'h000080, 24'h000080, 24'h000080, 1'b1};
        vecs[4] = '{24'h000080, 24'h000080, 24'h000000, 1'b1};
        vecs[5] = '{24'h000000, 24'h000000, 24'h000000, 1'b0};
        vecs[6] = '{24'h800001, 24'h000000, 24'h800001, 1'b0};
        vecs[7] = '{24'h000003, 24'h800000, 24'h000003, 1'b1};
        vecs[8] = '{24'h000000, 24'hFFFFFF, 24'h000000, 1'b1};
        vecs[9] = '{24'h000000, 24'h000000, 24'h000000, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_req", req, 0);
        check("rst_ctrlA", ctrlA, 0);
        check("rst_ctrlB", ctrlB, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_stat", resp_stat, 0);
        check("rst_resp_timeout", resp_timeout, 0);
        check("rst_pending", alarm_pending, 0);
        check("rst_irq", alarm_irq, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);

        // ALM_SET alarm 5 clock 3 loop 1, ready after 4 req cycles
        do_cmd(3'd4, 4'd3, 5'd5, 1'b1, 16'h0100, 3, 2'b01, "alm_set");
        check("alm_set_ctrlA_const", ctrlA, 16'h8658);
        check("alm_set_ctrlB_const", ctrlB, 16'h0100);

        do_cmd(3'd2, 4'd7, 5'd0, 1'b0, 16'h1234, TIMEOUT, 2'b11, "timeout");
        do_cmd(3'd7, 4'd0, 5'd0, 1'b0, 16'h00A5, TIMEOUT - 1, 2'b10, "edge_ready");
        do_cmd(3'd5, 4'd2, 5'd30, 1'b0, 16'h0000, 0, 2'b11, "alarm_oor");

        // back-to-back with cmd_valid held high
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_clock = 4'd0;
        cmd_alarm = 5'd0;
        cmd_loop  = 1'b0;
        cmd_value = 16'h0000;
        @(negedge clk);
        check("b2b_first_req", req, 1);
        check("b2b_first_ctrlA", ctrlA, 16'h2000);
        cmd_op    = 3'd3;
        cmd_clock = 4'd1;
        cmd_value = 16'hFFFF;
        stat      = 2'b10;
        ready     = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("b2b_first_resp", resp_valid, 1);
        check("b2b_first_stat", resp_stat, 2'b10);
        gap = 0;
        while (!req && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("b2b_req_gap", gap, 2);
        check("b2b_second_ctrlA", ctrlA, 16'h6200);
        check("b2b_second_ctrlB", ctrlB, 16'hFFFF);
        stat  = 2'b11;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("b2b_second_resp", resp_valid, 1);
        check("b2b_second_stat", resp_stat, 2'b11);
        @(negedge clk);

        // reset while req is high and ready low
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        cmd_clock = 4'd9;
        cmd_alarm = 5'd17;
        cmd_value = 16'hBEEF;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_req_before", req, 1);
        reset = 1'b1;
        data  = 24'h000010;
        @(negedge clk);
        check("midrst_req", req, 0);
        check("midrst_ctrlA", ctrlA, 0);
        check("midrst_ctrlB", ctrlB, 0);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_resp_stat", resp_stat, 0);
        check("midrst_pending", alarm_pending, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_edge_at_release", alarm_pending, 24'h000010);
        check("midrst_no_resp_a", resp_valid, 0);
        @(negedge clk);
        check("midrst_irq", alarm_irq, 1);
        check("midrst_no_resp_b", resp_valid, 0);
        data        = 24'h0;
        alarm_clear = 24'h000010;
        @(negedge clk);
        alarm_clear = 24'h0;
        check("midrst_cleared", alarm_pending, 0);
        do_cmd(3'd1, 4'd4, 5'd0, 1'b0, 16'h0042, 2, 2'b01, "after_rst");

        // alarm monitor vector table from a clean history
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            data        = vecs[k].d;
            alarm_clear = vecs[k].clr;
            @(negedge clk);
            check($sformatf("alm_vec%0d_pending", k), alarm_pending, vecs[k].pend);
            check($sformatf("alm_vec%0d_irq", k), alarm_irq, vecs[k].irq);
        end

        // randomized commands
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 7) == 0) dly = TIMEOUT + int'($urandom_range(0, 5));
            else dly = int'($urandom_range(0, 10));
            do_cmd(3'($urandom), 4'($urandom), 5'($urandom), 1'($urandom), 16'($urandom),
                   dly, 2'($urandom), $sformatf("rand_cmd%0d", k));
        end

        // randomized alarm monitor against a per-bit reference
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        prev  = '0;
        mp    = '0;
        np    = '0;
        for (int k = 0; k < 150; k++) begin
            d           = 24'($urandom & $urandom);
            c           = 24'($urandom & $urandom & $urandom);
            data        = d;
            alarm_clear = c;
            for (int i = 0; i < 24; i++) begin
                if (d[i] && !prev[i]) np[i] = 1'b1;
                else if (c[i])        np[i] = 1'b0;
                else                  np[i] = mp[i];
            end
            eirq = (mp != 0);
            @(negedge clk);
            check($sformatf("rand_alm%0d_pending", k), alarm_pending, np);
            check($sformatf("rand_alm%0d_irq", k), alarm_irq, eirq);
            prev = d;
            mp   = np;
        end
        data        = '0;
        alarm_clear = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got time limit, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
